// File: rtl/ping_echo_responder.sv
// Device-side ultrasonic ping responder. It watches the shared sig line for a
// host trigger pulse, waits a holdoff with the line pulled low, then drives an
// echo pulse whose width in clk cycles is the host-programmed distance value.
module ping_echo_responder #(
    parameter int unsigned MIN_TRIG = 200,
    parameter int unsigned HOLDOFF  = 75000,
    parameter int unsigned ECHO_MAX = 1850000,
    parameter int unsigned DEAD     = 20000,
    parameter int unsigned ECHO_DEF = 5800
) (
    input  logic        clk,
    input  logic        rst,
    inout  wire         sig,
    input  logic [31:0] echo_len,
    input  logic        load,
    output logic        busy,
    output logic [15:0] pulse_cnt,
    output logic [7:0]  glitch_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_TRIG = 3'd1,
        ST_HOLD = 3'd2,
        ST_ECHO = 3'd3,
        ST_DEAD = 3'd4
    } state_t;

    localparam logic [31:0] MIN_TRIG_C  = 32'(MIN_TRIG);
    localparam logic [31:0] HOLD_LAST   = 32'(HOLDOFF - 1);
    localparam logic [31:0] DEAD_LAST   = 32'(DEAD - 1);
    localparam logic [31:0] ECHO_MAX_C  = 32'(ECHO_MAX);
    localparam logic [31:0] ECHO_DEF_C  = 32'(ECHO_DEF);

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] width_reg_q, width_reg_d;
    logic [31:0] echo_len_reg_q, echo_len_reg_d;
    logic [15:0] pulse_cnt_q, pulse_cnt_d;
    logic [7:0]  glitch_cnt_q, glitch_cnt_d;
    logic        sync1_q;
    logic        sig_s_q;
    logic        sig_s_prev_q;

    logic [31:0] cnt_inc;
    logic [31:0] width_clamped;
    logic        trig_rise;
    logic        sig_oe;
    logic        sig_out;

    // Counter never wraps: a trigger held forever just parks at all-ones.
    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 32'd1;

    // Zero and out-of-range requests both mean "no object" (maximum width).
    assign width_clamped = ((echo_len_reg_q == 32'd0) || (echo_len_reg_q > ECHO_MAX_C))
                           ? ECHO_MAX_C : echo_len_reg_q;

    // Only a fresh 0->1 transition arms the responder; a stuck-high line does not.
    assign trig_rise = sig_s_q && !sig_s_prev_q;

    // Pin driver: purely a function of registered state, never of sig itself.
    assign sig = sig_oe ? sig_out : 1'bz;

    // State register plus all datapath flops, synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            cnt_q          <= 32'd0;
            width_reg_q    <= ECHO_MAX_C;
            echo_len_reg_q <= ECHO_DEF_C;
            pulse_cnt_q    <= 16'd0;
            glitch_cnt_q   <= 8'd0;
            sync1_q        <= 1'b0;
            sig_s_q        <= 1'b0;
            sig_s_prev_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            width_reg_q    <= width_reg_d;
            echo_len_reg_q <= echo_len_reg_d;
            pulse_cnt_q    <= pulse_cnt_d;
            glitch_cnt_q   <= glitch_cnt_d;
            sync1_q        <= sig;
            sig_s_q        <= sync1_q;
            sig_s_prev_q   <= sig_s_q;
        end
    end

    // Next-state and counter updates; cnt restarts from zero on every state entry.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        width_reg_d    = width_reg_q;
        pulse_cnt_d    = pulse_cnt_q;
        glitch_cnt_d   = glitch_cnt_q;
        echo_len_reg_d = load ? echo_len : echo_len_reg_q;
        case (state_q)
            ST_IDLE: begin
                if (trig_rise) begin
                    state_d = ST_TRIG;
                    cnt_d   = 32'd1;
                end
            end
            ST_TRIG: begin
                if (sig_s_q) begin
                    cnt_d = cnt_inc;
                end else if (cnt_q >= MIN_TRIG_C) begin
                    state_d     = ST_HOLD;
                    cnt_d       = 32'd0;
                    width_reg_d = width_clamped;
                end else begin
                    state_d = ST_IDLE;
                    cnt_d   = 32'd0;
                    if (glitch_cnt_q != 8'hFF) begin
                        glitch_cnt_d = glitch_cnt_q + 8'd1;
                    end
                end
            end
            ST_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = ST_ECHO;
                    cnt_d   = 32'd0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_ECHO: begin
                if (cnt_q == width_reg_q - 32'd1) begin
                    state_d     = ST_DEAD;
                    cnt_d       = 32'd0;
                    pulse_cnt_d = pulse_cnt_q + 16'd1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_DEAD: begin
                if (cnt_q == DEAD_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = 32'd0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 32'd0;
            end
        endcase
    end

    // Outputs decoded from the registered state only.
    always_comb begin
        sig_oe  = 1'b0;
        sig_out = 1'b0;
        case (state_q)
            ST_HOLD: begin
                sig_oe  = 1'b1;
                sig_out = 1'b0;
            end
            ST_ECHO: begin
                sig_oe  = 1'b1;
                sig_out = 1'b1;
            end
            default: begin
                sig_oe  = 1'b0;
                sig_out = 1'b0;
            end
        endcase
        busy = (state_q != ST_IDLE);
    end

    assign pulse_cnt  = pulse_cnt_q;
    assign glitch_cnt = glitch_cnt_q;

endmodule

// File: tb/tb_ping_echo_responder.sv
// Directed bench for ping_echo_responder with small timing parameters.
// Each ping is captured cycle by cycle from the edge the trigger is first seen
// low (index 0) and reduced to phase start/length numbers for comparison.
module tb_ping_echo_responder;

    localparam int H  = 10;
    localparam int DW = 20;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [31:0] echo_len;
    logic        busy;
    logic [15:0] pulse_cnt;
    logic [7:0]  glitch_cnt;
    logic        tb_en;
    logic        tb_val;
    wire         sig;
    logic        sig_is_z;

    assign sig      = tb_en ? tb_val : 1'bz;
    assign sig_is_z = (sig === 1'bz);

    always #5 clk = ~clk;

    ping_echo_responder #(
        .MIN_TRIG (4),
        .HOLDOFF  (10),
        .ECHO_MAX (100),
        .DEAD     (20),
        .ECHO_DEF (50)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sig        (sig),
        .echo_len   (echo_len),
        .load       (load),
        .busy       (busy),
        .pulse_cnt  (pulse_cnt),
        .glitch_cnt (glitch_cnt)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [1:0] code_a [0:199];
    logic       busy_a [0:199];
    int t_low, n_low, n_high, t_idle;
    logic [1:0] rel_code;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    function automatic logic [1:0] pin_code();
        return sig_is_z ? 2'd2 : {1'b0, sig};
    endfunction

    // Drive the pin high for w sampled cycles, then release it.
    task automatic pulse(input int w);
        @(posedge clk);
        #1;
        tb_val = 1'b1;
        tb_en  = 1'b1;
        repeat (w) @(posedge clk);
        #1;
        tb_en  = 1'b0;
        tb_val = 1'b0;
    endtask

    task automatic do_load(input logic [31:0] v);
        @(negedge clk);
        load     = 1'b1;
        echo_len = v;
        @(negedge clk);
        load     = 1'b0;
    endtask

    // Record pin code and busy after each of len edges starting at edge N.
    task automatic capture(input int len, input int load_k, input logic [31:0] load_v);
        for (int k = 0; k < len; k++) begin
            @(posedge clk);
            @(negedge clk);
            code_a[k] = pin_code();
            busy_a[k] = busy;
            if (k == load_k) begin
                load     = 1'b1;
                echo_len = load_v;
            end else begin
                load = 1'b0;
            end
        end
        load = 1'b0;
    endtask

    task automatic analyze(input int len);
        int k;
        t_low  = -1;
        n_low  = 0;
        n_high = 0;
        t_idle = -1;
        rel_code = 2'd3;
        for (int i = 0; i < len; i++) begin
            if (t_low < 0 && code_a[i] != 2'd2) t_low = i;
        end
        if (t_low >= 0) begin
            k = t_low;
            while (k < len && code_a[k] == 2'd0) begin n_low++; k++; end
            while (k < len && code_a[k] == 2'd1) begin n_high++; k++; end
            if (k < len) rel_code = code_a[k];
        end
        for (int i = 0; i < len; i++) begin
            if (t_idle < 0 && !busy_a[i]) t_idle = i;
        end
    endtask

    task automatic ping(input string tag, input int w_trig, input int w_exp,
                        input int load_k, input logic [31:0] load_v);
        int len;
        len = 2 + H + w_exp + DW + 2;
        pulse(w_trig);
        capture(len, load_k, load_v);
        analyze(len);
        check($sformatf("%s_low_start", tag), t_low, 2);
        check($sformatf("%s_low_len", tag), n_low, H);
        check($sformatf("%s_echo_len", tag), n_high, w_exp);
        check($sformatf("%s_release_z", tag), {30'd0, rel_code}, 2);
        check($sformatf("%s_idle_at", tag), t_idle, 2 + H + w_exp + DW);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int rises;
        logic prev_busy;
        rst = 1'b1; load = 1'b0; echo_len = 32'd0; tb_en = 1'b0; tb_val = 1'b0;

        // 1: reset state, default echo width
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_sig_z", {30'd0, pin_code()}, 2);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_pulse_cnt", {16'd0, pulse_cnt}, 0);
        check("rst_glitch_cnt", {24'd0, glitch_cnt}, 0);
        rst = 1'b0;
        ping("def", 5, 50, -1, 0);
        check("def_pulse_cnt", {16'd0, pulse_cnt}, 1);

        // 2: programmed width, then minimum-width trigger boundary
        do_reset();
        check("t2_rst_pulse_cnt", {16'd0, pulse_cnt}, 0);
        do_load(32'd30);
        ping("w30", 5, 30, -1, 0);
        check("w30_pulse_cnt", {16'd0, pulse_cnt}, 1);
        ping("mintrig", 4, 30, -1, 0);
        check("mintrig_pulse_cnt", {16'd0, pulse_cnt}, 2);

        // 3: short triggers rejected, glitch counter saturates
        pulse(3);
        capture(6, -1, 0);
        analyze(6);
        check("glitch_no_drive", t_low, -1);
        check("glitch_busy_n1", {31'd0, busy_a[1]}, 1);
        check("glitch_busy_n2", {31'd0, busy_a[2]}, 0);
        check("glitch_cnt_1", {24'd0, glitch_cnt}, 1);
        for (int i = 0; i < 299; i++) begin
            pulse(3);
            repeat (4) @(posedge clk);
        end
        @(negedge clk);
        check("glitch_cnt_sat", {24'd0, glitch_cnt}, 255);
        check("glitch_pulse_cnt", {16'd0, pulse_cnt}, 2);

        // 4: clamping and load taking effect only at next acceptance
        do_load(32'd0);
        ping("zero", 5, 100, -1, 0);
        do_load(32'd500);
        ping("over", 5, 100, -1, 0);
        ping("midload", 5, 100, 2 + H + 5, 32'd70);
        ping("w70", 5, 70, -1, 0);
        check("t4_pulse_cnt", {16'd0, pulse_cnt}, 6);

        // 5: line held high across DEAD->IDLE must not retrigger
        pulse(5);
        capture(2 + H + 70 + 10, -1, 0);
        analyze(2 + H + 70 + 10);
        check("hold_low_start", t_low, 2);
        check("hold_echo_len", n_high, 70);
        tb_val = 1'b1;
        tb_en  = 1'b1;
        rises = 0;
        prev_busy = busy;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (busy && !prev_busy) rises++;
            prev_busy = busy;
        end
        check("hold_no_retrigger", rises, 0);
        check("hold_busy_end", {31'd0, busy}, 0);
        tb_en  = 1'b0;
        tb_val = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("hold_fall_busy", {31'd0, busy}, 0);
        ping("after_hold", 5, 70, -1, 0);
        check("t5_pulse_cnt", {16'd0, pulse_cnt}, 8);

        // 6: reset in the middle of an echo
        pulse(5);
        capture(24, -1, 0);
        analyze(24);
        check("abort_low_len", n_low, H);
        check("abort_echo_so_far", n_high, 12);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort_sig_z", {30'd0, pin_code()}, 2);
        check("abort_busy", {31'd0, busy}, 0);
        check("abort_pulse_cnt", {16'd0, pulse_cnt}, 0);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        ping("post_abort", 5, 50, -1, 0);
        check("post_abort_pulse_cnt", {16'd0, pulse_cnt}, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ping_echo_responder.md
Name: ping_echo_responder

Overview:
- Device-side responder for the single-wire ultrasonic ping protocol that sonic_sensor initiates on its sig line.
- Detects the host trigger pulse on the shared inout pin, waits a holdoff, then drives an echo pulse whose width in clk cycles equals a host-programmed distance value.
- Used as a hardware-in-loop sensor emulator. Its echo_len / load pair is written from the 32-bit host write FIFO path.

Parameters:
MIN_TRIG, 200, minimum synchronized trigger high width in clk cycles for a valid trigger
HOLDOFF, 75000, cycles sig is driven low between trigger acceptance and echo rise
ECHO_MAX, 1850000, maximum echo width in cycles; also the "no object" width
DEAD, 20000, cycles sig is released after echo before re-arming
ECHO_DEF, 5800, echo_len_reg value after reset

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
sig  inout  1  shared ping line; trigger in, echo out
echo_len  in  32  requested echo width in cycles
load  in  1  one-cycle strobe; captures echo_len into echo_len_reg
busy  out  1  high when state != IDLE
pulse_cnt  out  16  completed echoes, wraps at 65535 -> 0
glitch_cnt  out  8  rejected short triggers, saturates at 255

Behaviour:
- Reset (rst sampled high at a clk edge):
  - state = IDLE; sig released (Z) from that edge.
  - busy = 0, pulse_cnt = 0, glitch_cnt = 0, cycle counter = 0.
  - echo_len_reg = ECHO_DEF; synchronizer flops = 0.
  - Reset mid-operation aborts immediately with no completion count.
- Input path: sig passes through a 2-flop synchronizer into sig_s. The sig_s_d history flop is used for rising-edge detection.
- Pin drive is decoded from the registered state only, with no combinational path from sig:
  - HOLD: drive 0.
  - ECHO: drive 1.
  - All other states: Z.
- load: echo_len_reg <= echo_len whenever load = 1, in any state. It takes effect only at the next trigger acceptance.
- Width latch: at the TRIG->HOLD transition, width_reg <= clamp(echo_len_reg):
  - 0 maps to ECHO_MAX.
  - Values > ECHO_MAX map to ECHO_MAX.
  - Otherwise the value is used unchanged.
- State machine (cnt is a 32-bit cycle counter, cleared on every state entry):
  - IDLE: on rising edge of sig_s (sig_s = 1 and sig_s_d = 0) -> TRIG, cnt = 1. A level that is already high on entry is ignored.
  - TRIG, sig_s = 1: cnt++, saturating.
  - TRIG, sig_s = 0, cnt >= MIN_TRIG: -> HOLD; latch width_reg.
  - TRIG, sig_s = 0, cnt < MIN_TRIG: -> IDLE; glitch_cnt++ (saturating).
  - HOLD: cnt == HOLDOFF-1 -> ECHO.
  - ECHO: cnt == width_reg-1 -> DEAD; pulse_cnt++ on this transition.
  - DEAD: cnt == DEAD-1 -> IDLE. Pin activity in DEAD is ignored.
- Timing, where N = first clk edge at which the pin is sampled low after a valid trigger:
  - HOLD is entered and sig driven low from edge N+2.
  - sig driven high from edge N+2+HOLDOFF for exactly width_reg cycles.
  - sig released at edge N+2+HOLDOFF+width_reg.
- Trigger width is measured in sig_s cycles, which equal pin-high cycles.
- A trigger held high across DEAD->IDLE produces no response until the pin falls and rises again.
- Trigger still high at saturation: remain in TRIG until it falls.

Test Plan (MIN_TRIG=4, HOLDOFF=10, ECHO_MAX=100, DEAD=20, ECHO_DEF=50):
1. Assert rst 3 cycles -> sig Z, busy=0, pulse_cnt=0, glitch_cnt=0. Trigger 5 cycles with no load -> echo exactly 50 cycles.
2. load echo_len=30, drive sig high 5 cycles then release -> sig=0 from N+2 for 10 cycles, sig=1 for exactly 30 cycles, then Z. pulse_cnt=1; busy=0 after 20 DEAD cycles.
3. Trigger high 3 cycles -> sig stays Z, glitch_cnt=1, busy returns 0 three cycles after the pin falls. Repeat 300 times -> glitch_cnt=255.
4. load echo_len=0 -> echo width 100. load echo_len=500 -> echo width 100. load echo_len=70 during ECHO -> current echo unchanged, next echo is 70.
5. Hold bench drive high from mid-DEAD through DEAD->IDLE -> no response. Release, then a 5-cycle trigger -> normal response.
6. Assert rst at ECHO cycle 12 -> sig Z at that edge, busy=0, pulse_cnt=0. A following valid trigger -> full normal sequence.
